// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W decoder with one-hot/thermometer output and an
// auto-scan sequencer that sweeps the index with a programmable dwell.
module decoder_scan #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  scan,
  input  logic                  therm,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  active,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_n;
  logic [SEL_W-1:0]   idx_n;
  logic [OUT_W-1:0]   y_n;
  logic               active_n;
  logic               wrap_n;

  function automatic logic [OUT_W-1:0] encode(input logic [SEL_W-1:0] i,
                                              input logic th);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < OUT_W; k++)
      r[k] = th ? (SEL_W'(k) <= i) : (SEL_W'(k) == i);
    return r;
  endfunction

  always_comb begin
    idx_n    = idx;
    cnt_n    = cnt;
    active_n = active;
    y_n      = y;
    wrap_n   = 1'b0;
    if (clr) begin
      cnt_n    = '0;
      active_n = 1'b0;
      y_n      = '0;
    end else if (en) begin
      if (load) begin
        idx_n    = sel;
        cnt_n    = '0;
        active_n = 1'b1;
        y_n      = encode(sel, therm);
      end else if (active) begin
        if (scan) begin
          // >= rather than == so a dwell lowered mid-count still steps at once
          if (cnt >= dwell) begin
            cnt_n  = '0;
            idx_n  = idx + SEL_W'(1);
            wrap_n = (idx == '1);
          end else begin
            cnt_n = cnt + DWELL_W'(1);
          end
        end else begin
          cnt_n = '0;
        end
        y_n = encode(idx_n, therm);
      end else begin
        cnt_n = '0;
        y_n   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      y      <= '0;
      wrap   <= 1'b0;
    end else begin
      idx    <= idx_n;
      cnt    <= cnt_n;
      active <= active_n;
      y      <= y_n;
      wrap   <= wrap_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: directed sequences plus a randomized phase, all
// checked every cycle against a behavioural model of the decode/scan rules.
module tb_decoder_scan;

  localparam int SEL_W   = 4;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 16;

  logic               clk = 1'b0;
  logic               rst, en, clr, load, scan, therm;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               active, wrap;

  int checks   = 0;
  int failures = 0;

  int m_idx, m_cnt;
  bit m_act, m_wrap;
  logic [31:0] m_y;

  decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .sel(sel),
    .scan(scan), .therm(therm), .dwell(dwell),
    .y(y), .idx(idx), .active(active), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int i, input bit th);
    return th ? ((32'd1 << (i + 1)) - 32'd1) : (32'd1 << i);
  endfunction

  // Model update from the inputs seen at the clock edge.
  task automatic model_edge();
    if (rst) begin
      m_idx = 0; m_cnt = 0; m_act = 0; m_wrap = 0; m_y = 0;
    end else if (clr) begin
      m_cnt = 0; m_act = 0; m_wrap = 0; m_y = 0;
    end else if (!en) begin
      m_wrap = 0;
    end else if (load) begin
      m_idx = int'(sel); m_cnt = 0; m_act = 1; m_wrap = 0;
      m_y = enc(m_idx, therm);
    end else if (m_act) begin
      m_wrap = 0;
      if (scan) begin
        if (m_cnt >= int'(dwell)) begin
          m_cnt = 0;
          m_wrap = (m_idx == OUT_W - 1);
          m_idx = (m_idx + 1) % OUT_W;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
      end
      m_y = enc(m_idx, therm);
    end else begin
      m_cnt = 0; m_wrap = 0; m_y = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("y",      32'(y),      m_y);
    check("idx",    32'(idx),    32'(m_idx));
    check("active", 32'(active), 32'(m_act));
    check("wrap",   32'(wrap),   32'(m_wrap));
  endtask

  task automatic idle();
    rst = 0; clr = 0; load = 0; en = 1;
  endtask

  int exp_idx [9] = '{14, 14, 15, 15, 15, 0, 0, 0, 1};
  bit exp_wrap[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    m_idx = 0; m_cnt = 0; m_act = 0; m_wrap = 0; m_y = 0;
    rst = 1; en = 1; clr = 0; load = 0; sel = '0; scan = 0; therm = 0;
    dwell = '0;
    step();
    check("rst_y", 32'(y), 32'h0);
    check("rst_active", 32'(active), 32'h0);

    // Static one-hot
    idle(); load = 1; sel = 4'd5;
    step();
    check("load5_y", 32'(y), 32'h0020);
    load = 0;
    repeat (10) step();
    check("hold5_y", 32'(y), 32'h0020);

    // Thermometer and therm toggle
    therm = 1; step();
    check("therm5_y", 32'(y), 32'h003F);
    load = 1; sel = 4'd15; step();
    check("therm15_y", 32'(y), 32'hFFFF);
    load = 0; therm = 0; step();
    check("onehot15_y", 32'(y), 32'h8000);

    // Scan with dwell=2 across the wrap
    dwell = 8'd2; scan = 1; load = 1; sel = 4'd14; step();
    check("scan_start", 32'(idx), 32'd14);
    load = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      check("scan_idx", 32'(idx), 32'(exp_idx[i]));
      check("scan_wrap", 32'(wrap), 32'(exp_wrap[i]));
      if (exp_wrap[i]) check("wrap_y", 32'(y), 32'h0001);
    end

    // dwell=0 with en gating
    dwell = 8'd0; load = 1; sel = 4'd0; step();
    check("load0_wrap", 32'(wrap), 32'h0);
    load = 0;
    repeat (7) step();
    check("at7", 32'(idx), 32'd7);
    en = 0;
    repeat (4) step();
    check("frozen_idx", 32'(idx), 32'd7);
    check("frozen_y", 32'(y), 32'h0080);
    check("frozen_wrap", 32'(wrap), 32'h0);
    en = 1; step();
    check("resume_idx", 32'(idx), 32'd8);

    // Priority and simultaneity
    dwell = 8'd2; load = 1; sel = 4'd10; step();
    load = 0; step(); step();
    load = 1; sel = 4'd3; step();
    check("load_over_step", 32'(idx), 32'd3);
    load = 0; step();
    check("fresh_dwell", 32'(idx), 32'd3);
    clr = 1; load = 1; sel = 4'd6; step();
    check("clr_load_y", 32'(y), 32'h0);
    check("clr_load_act", 32'(active), 32'h0);
    clr = 0; load = 1; sel = 4'd9; step();
    rst = 1; clr = 1; load = 1; step();
    check("rst_all_idx", 32'(idx), 32'h0);
    check("rst_all_act", 32'(active), 32'h0);

    // Dwell reduced mid-count, then mid-scan clr
    idle(); dwell = 8'd200; load = 1; sel = 4'd4; step();
    load = 0;
    repeat (50) step();
    check("long_dwell_idx", 32'(idx), 32'd4);
    dwell = 8'd1; step();
    check("dwell_cut_idx", 32'(idx), 32'd5);
    clr = 1; step();
    check("midscan_clr_y", 32'(y), 32'h0);
    clr = 0;
    repeat (5) step();
    check("halted_idx", 32'(idx), 32'd5);
    check("halted_y", 32'(y), 32'h0);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      clr   = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 7) != 0);
      sel   = SEL_W'($urandom);
      if ($urandom_range(0, 19) == 0) scan  = ~scan;
      if ($urandom_range(0, 15) == 0) therm = ~therm;
      if ($urandom_range(0, 24) == 0)
        dwell = ($urandom_range(0, 9) == 0) ? DWELL_W'($urandom)
                                            : DWELL_W'($urandom_range(0, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
